anillo_multiplexor: RTL

ANILLO_MULTIPLEXOR -- requirements
Module: anillo_multiplexor

---
 rtl/anillo_multiplexor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/anillo_multiplexor.sv
// Time-multiplexed digit scanner: rotates over the unmasked digits, blanks the anodes
// at the start of each slot and drives one active-low anode. Optional dimming: ANILLO_MULTIPLEXOR_DIM_EN.
module anillo_multiplexor #(
    parameter int N_DIG = 4,
    parameter int SEL_W = 2,
    parameter int SLOT  = 1000,
    parameter int DEAD  = 8
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Enable,
    input  logic [N_DIG-1:0] i_DigMask,
`ifdef ANILLO_MULTIPLEXOR_DIM_EN
    input  logic [3:0]       i_Brillo,
`endif
    output logic [SEL_W-1:0] o_Sel,
    output logic [N_DIG-1:0] o_Anodos,
    output logic             o_Tick
);

    localparam int               CNT_W    = (SLOT > 2) ? $clog2(SLOT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);

    generate
        if ((N_DIG < 2) || (N_DIG > 8) || ((1 << SEL_W) < N_DIG) ||
            (DEAD < 1) || (SLOT < DEAD + 2)) begin : g_param_check
            $error("anillo_multiplexor: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DEAD = 2'd1,
        ST_ON   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N_DIG-1:0]   anodos_q, anodos_d;
    logic               tick_q, tick_d;

    logic               next_found;
    logic [SEL_W-1:0]   next_sel;
    logic [SEL_W-1:0]   cand;
    logic               drive_on;

    // Nearest enabled digit strictly after sel_q, wrapping; offset N_DIG lands back on
    // sel_q itself so a lone enabled digit is still found. Scanning from the far end
    // lets the closest hit overwrite the others.
    always_comb begin
        next_found = 1'b0;
        next_sel   = sel_q;
        cand       = '0;
        for (int k = N_DIG; k >= 1; k--) begin
            cand = SEL_W'((int'(sel_q) + k) % N_DIG);
            if (i_DigMask[cand]) begin
                next_found = 1'b1;
                next_sel   = cand;
            end
        end
    end

`ifdef ANILLO_MULTIPLEXOR_DIM_EN
    logic [3:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d = pwm_q + 4'd1;
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    // Compared against the value the counter will hold while this drive is visible.
    assign drive_on = (pwm_d < i_Brillo);
`else
    assign drive_on = 1'b1;
`endif

    // NOTE: every signal gets a default before any branch, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        tick_d   = 1'b0;
        anodos_d = '1;

        if (!i_Enable) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            if (state_q == ST_OFF) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (next_found) begin
                    sel_d  = next_sel;
                    tick_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = (cnt_d < CNT_DEAD) ? ST_DEAD : ST_ON;
        end

        // Outputs are decoded from next-state values so the registered anodes line
        // up with the state and counter they belong to.
        if ((state_d == ST_ON) && i_DigMask[sel_d]) begin
            anodos_d[sel_d] = ~drive_on;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            sel_q    <= '0;
            anodos_q <= '1;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            anodos_q <= anodos_d;
            tick_q   <= tick_d;
        end
    end

    assign o_Sel    = sel_q;
    assign o_Anodos = anodos_q;
    assign o_Tick   = tick_q;

endmodule
